// File: rtl/dmem_responder_if.sv
// D-memory port bundle between the core's MEM stage (master) and the memory responder (slave).
interface dmem_responder_if #(
   parameter int ADDR_W = 10
);
   logic              ceb;
   logic              web;
   logic [ADDR_W-1:0] A;
   logic [3:0]        mask;
   logic [31:0]       D;
   logic [31:0]       Q;
   logic              q_valid;
   logic              ready;
   logic              acc_err;

   modport master (
      output ceb, web, A, mask, D,
      input  Q, q_valid, ready, acc_err
   );

   modport slave (
      input  ceb, web, A, mask, D,
      output Q, q_valid, ready, acc_err
   );
endinterface

// File: rtl/dmem_responder.sv
// D-memory responder: byte-masked word array with a self-clear after reset, a configurable
// read latency and a pulse flag for dropped (not ready or out-of-range) requests.
module dmem_responder #(
   parameter int ADDR_W       = 10,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

   state_t                         state;
   logic [IDX_W-1:0]               clr_cnt;
   logic                           ready;
   logic                           acc_err;
   logic [31:0]                    mem [0:DEPTH-1];
   logic [READ_LATENCY-1:0]        pipe_v;
   logic [READ_LATENCY-1:0][31:0]  pipe_d;

   logic [IDX_W-1:0]               idx;
   logic                           req;
   logic                           in_range;
   logic                           ok;
   logic                           rd;
   logic                           wr;
   logic [31:0]                    rd_word;

   // Request decode; dropped reads carry a zero word so the requester still gets a reply.
   always_comb begin
      idx      = bus.A[IDX_W-1:0];
      req      = ~bus.ceb;
      in_range = ({1'b0, bus.A} < (ADDR_W+1)'(DEPTH));
      ok       = ready & in_range;
      rd       = req & bus.web;
      wr       = req & ~bus.web & ok;
      if (rd && ok) begin
         rd_word = mem[idx];
      end else begin
         rd_word = 32'h0000_0000;
      end
   end

   // Clear/serve FSM: walks clr_cnt over the whole array once, then serves until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + IDX_W'(1);
               if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                  state <= SERVE;
                  ready <= 1'b1;
               end
            end
            SERVE: begin
               ready <= 1'b1;
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= '0;
               ready   <= 1'b0;
            end
         endcase
      end
   end

   // Word array; requests are dropped while clearing, so the two write sources never collide.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_cnt] <= 32'h0000_0000;
      end else if (wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.mask[i]) begin
               mem[idx][8*i +: 8] <= bus.D[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline; the last stage is the Q register and only loads when a read arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_v <= '0;
         pipe_d <= '0;
      end else begin
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            if ((i != READ_LATENCY - 1) || pipe_v[i-1]) begin
               pipe_d[i] <= pipe_d[i-1];
            end
         end
         pipe_v[0] <= rd;
         if ((READ_LATENCY != 1) || rd) begin
            pipe_d[0] <= rd_word;
         end
      end
   end

   // Dropped-request flag, one cycle after the offending edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_err <= 1'b0;
      end else begin
         acc_err <= req & ~ok;
      end
   end

   assign bus.Q       = pipe_d[READ_LATENCY-1];
   assign bus.q_valid = pipe_v[READ_LATENCY-1];
   assign bus.ready   = ready;
   assign bus.acc_err = acc_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Drives two responders (read latency 1 and 3, DEPTH=16) with one stimulus stream and checks both
// against an array/queue model of the memory port.
module tb_dmem_responder;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 10;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        ceb   = 1'b1;
   logic        web   = 1'b1;
   logic [9:0]  a     = 10'd0;
   logic [3:0]  mask  = 4'd0;
   logic [31:0] d     = 32'd0;

   always #5 clk = ~clk;

   dmem_responder_if #(.ADDR_W(ADDR_W)) bus1 ();
   dmem_responder_if #(.ADDR_W(ADDR_W)) bus3 ();

   assign bus1.ceb = ceb;  assign bus1.web = web;  assign bus1.A = a;
   assign bus1.mask = mask; assign bus1.D = d;
   assign bus3.ceb = ceb;  assign bus3.web = web;  assign bus3.A = a;
   assign bus3.mask = mask; assign bus3.D = d;

   dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );
   dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(3)) u3 (
      .clk(clk), .reset(reset), .bus(bus3)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;

   resp_t       exp1[$];
   resp_t       exp3[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] hold1, hold3;
   logic        err_exp;
   int          cyc;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      logic ev1, ev3;
      ev1 = 1'b0;
      ev3 = 1'b0;
      if (exp1.size() > 0 && exp1[0].due == cyc) begin
         ev1 = 1'b1; hold1 = exp1[0].data; void'(exp1.pop_front());
      end
      if (exp3.size() > 0 && exp3[0].due == cyc) begin
         ev3 = 1'b1; hold3 = exp3[0].data; void'(exp3.pop_front());
      end
      check($sformatf("lat1.q_valid@%0d", cyc), 32'(bus1.q_valid), 32'(ev1));
      check($sformatf("lat1.Q@%0d", cyc), bus1.Q, hold1);
      check($sformatf("lat1.ready@%0d", cyc), 32'(bus1.ready), 32'(cyc >= DEPTH));
      check($sformatf("lat1.acc_err@%0d", cyc), 32'(bus1.acc_err), 32'(err_exp));
      check($sformatf("lat3.q_valid@%0d", cyc), 32'(bus3.q_valid), 32'(ev3));
      check($sformatf("lat3.Q@%0d", cyc), bus3.Q, hold3);
      check($sformatf("lat3.ready@%0d", cyc), 32'(bus3.ready), 32'(cyc >= DEPTH));
      check($sformatf("lat3.acc_err@%0d", cyc), 32'(bus3.acc_err), 32'(err_exp));
   endtask

   // One request cycle, starting and ending at a falling edge.
   task automatic step(input logic c, input logic w, input logic [9:0] aa,
                       input logic [3:0] mm, input logic [31:0] dd);
      logic        ok;
      logic [31:0] word;
      ceb = c; web = w; a = aa; mask = mm; d = dd;
      @(posedge clk);
      ok      = (cyc >= DEPTH) && (int'(aa) < DEPTH);
      err_exp = !c && !ok;
      cyc++;
      if (!c && w) begin
         word = ok ? ref_mem[aa[3:0]] : 32'h0;
         exp1.push_back('{due: cyc,     data: word});
         exp3.push_back('{due: cyc + 2, data: word});
      end
      if (!c && !w && ok) begin
         for (int i = 0; i < 4; i++) begin
            if (mm[i]) ref_mem[aa[3:0]][8*i +: 8] = dd[8*i +: 8];
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      step(1'b1, 1'b1, 10'd0, 4'd0, 32'd0);
   endtask

   task automatic do_reset();
      ceb = 1'b1; web = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("rst.lat1.Q", bus1.Q, 32'h0);
      check("rst.lat3.Q", bus3.Q, 32'h0);
      check("rst.lat1.qv_rdy_err", {29'd0, bus1.q_valid, bus1.ready, bus1.acc_err}, 32'h0);
      check("rst.lat3.qv_rdy_err", {29'd0, bus3.q_valid, bus3.ready, bus3.acc_err}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("rst.hold.lat3.q_valid", 32'(bus3.q_valid), 32'h0);
         check("rst.hold.lat3.Q", bus3.Q, 32'h0);
      end
      exp1.delete(); exp3.delete();
      hold1 = 32'h0; hold3 = 32'h0; err_exp = 1'b0; cyc = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Write during CLEAR is dropped, then the array must read back all zeros.
      idle();
      step(1'b0, 1'b0, 10'd0, 4'hF, 32'h1234_5678);
      while (cyc < DEPTH) idle();
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 10'(i), 4'd0, 32'd0);

      step(1'b0, 1'b0, 10'd3, 4'b0101, 32'hAABB_CCDD);
      step(1'b0, 1'b1, 10'd3, 4'd0, 32'd0);
      repeat (3) idle();

      step(1'b0, 1'b0, 10'd1, 4'hF, 32'h11);
      step(1'b0, 1'b0, 10'd2, 4'hF, 32'h22);
      step(1'b0, 1'b0, 10'd3, 4'hF, 32'h33);
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 10'(i), 4'd0, 32'd0);
      repeat (3) idle();

      step(1'b0, 1'b1, 10'd5, 4'd0, 32'd0);
      step(1'b0, 1'b0, 10'd5, 4'hF, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 10'd5, 4'd0, 32'd0);
      step(1'b0, 1'b0, 10'd4, 4'b0000, 32'hCAFE_F00D);
      repeat (3) idle();

      // Out of range: A=20 aliases word 4 in the low bits, so word 4 must stay untouched.
      step(1'b0, 1'b1, 10'd20, 4'd0, 32'd0);
      step(1'b0, 1'b0, 10'd20, 4'hF, 32'hDEAD_BEEF);
      step(1'b0, 1'b1, 10'd4, 4'd0, 32'd0);
      step(1'b0, 1'b1, 10'd1023, 4'd0, 32'd0);
      repeat (3) idle();

      for (int n = 0; n < 300; n++) begin
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 19)), 4'($urandom_range(0, 15)), 32'($urandom));
      end
      repeat (3) idle();

      // Reset one cycle after a read on the latency-3 responder.
      step(1'b0, 1'b1, 10'd2, 4'd0, 32'd0);
      idle();
      do_reset();
      while (cyc < DEPTH + 1) idle();
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 10'(i), 4'd0, 32'd0);
      repeat (3) idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
